// File: rtl/mem_arbiter.sv
// Two-port (fetch/data) arbiter onto a single fixed-latency memory port.
// Optional macro ARB_ROUND_ROBIN_EN: alternate on contention instead of DATA-first priority.
module mem_arbiter #(
    parameter int AWIDTH  = 32,
    parameter int DWIDTH  = 32,
    parameter int MEM_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              if_req_i,
    input  logic [AWIDTH-1:0] if_addr_i,
    output logic              if_gnt_o,
    output logic              if_rvalid_o,
    output logic [DWIDTH-1:0] if_rdata_o,

    input  logic              d_req_i,
    input  logic              d_we_i,
    input  logic [AWIDTH-1:0] d_addr_i,
    input  logic [DWIDTH-1:0] d_wdata_i,
    output logic              d_gnt_o,
    output logic              d_rvalid_o,
    output logic [DWIDTH-1:0] d_rdata_o,

    output logic [AWIDTH-1:0] mem_addr_o,
    output logic [DWIDTH-1:0] mem_data_o,
    output logic              mem_read_en_o,
    output logic              mem_write_en_o,
    input  logic [DWIDTH-1:0] mem_data_i,

    output logic              busy_o
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    typedef enum logic {
        OWN_IF   = 1'b0,
        OWN_DATA = 1'b1
    } owner_t;

    localparam logic [2:0] CNT_LOAD = 3'(MEM_LAT - 1);

    state_t            state_q, state_d;
    owner_t            owner_q, owner_d;
    owner_t            last_q,  last_d;
    logic [2:0]        cnt_q,   cnt_d;
    logic [AWIDTH-1:0] addr_q,  addr_d;
    logic              we_q,    we_d;
    logic [DWIDTH-1:0] wdata_q, wdata_d;
    logic [DWIDTH-1:0] resp_q,  resp_d;
    logic              first_q, first_d;

    logic pick_data;
    logic grant_data;
    logic grant_if;

    // Grants are gated by rst so they drop asynchronously with the rest of the outputs.
    always_comb begin
`ifdef ARB_ROUND_ROBIN_EN
        pick_data = !if_req_i || (last_q == OWN_IF);
`else
        pick_data = 1'b1;
`endif
        grant_data = rst && (state_q == S_IDLE) && d_req_i && pick_data;
        grant_if   = rst && (state_q == S_IDLE) && if_req_i && !grant_data;
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        we_d    = we_q;
        wdata_d = wdata_q;
        resp_d  = resp_q;
        first_d = first_q;

        case (state_q)
            S_IDLE: begin
                if (grant_data) begin
                    state_d = S_ACCESS;
                    owner_d = OWN_DATA;
                    last_d  = OWN_DATA;
                    addr_d  = d_addr_i;
                    we_d    = d_we_i;
                    wdata_d = d_wdata_i;
                    cnt_d   = CNT_LOAD;
                    first_d = 1'b1;
                end else if (grant_if) begin
                    state_d = S_ACCESS;
                    owner_d = OWN_IF;
                    last_d  = OWN_IF;
                    addr_d  = if_addr_i;
                    we_d    = 1'b0;
                    cnt_d   = CNT_LOAD;
                    first_d = 1'b1;
                end
            end
            S_ACCESS: begin
                first_d = 1'b0;
                if (cnt_q == 3'd0) begin
                    resp_d  = we_q ? '0 : mem_data_i;
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            owner_q <= OWN_IF;
            last_q  <= OWN_IF;
            cnt_q   <= '0;
            addr_q  <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            resp_q  <= '0;
            first_q <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
            resp_q  <= resp_d;
            first_q <= first_d;
        end
    end

    assign if_gnt_o       = grant_if;
    assign d_gnt_o        = grant_data;
    assign mem_addr_o     = addr_q;
    assign mem_data_o     = wdata_q;
    assign mem_read_en_o  = (state_q == S_ACCESS) && first_q && !we_q;
    assign mem_write_en_o = (state_q == S_ACCESS) && first_q && we_q;
    assign if_rvalid_o    = (state_q == S_RESP) && (owner_q == OWN_IF);
    assign d_rvalid_o     = (state_q == S_RESP) && (owner_q == OWN_DATA);
    assign if_rdata_o     = resp_q;
    assign d_rdata_o      = resp_q;
    assign busy_o         = (state_q != S_IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized bench for mem_arbiter against a transaction-timing reference model.
// Honours ARB_ROUND_ROBIN_EN to match the DUT build.
module tb_mem_arbiter;

    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req_i;
    logic [31:0] if_addr_i;
    logic        if_gnt_o;
    logic        if_rvalid_o;
    logic [31:0] if_rdata_o;
    logic        d_req_i;
    logic        d_we_i;
    logic [31:0] d_addr_i;
    logic [31:0] d_wdata_i;
    logic        d_gnt_o;
    logic        d_rvalid_o;
    logic [31:0] d_rdata_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_data_o;
    logic        mem_read_en_o;
    logic        mem_write_en_o;
    logic [31:0] mem_data_i;
    logic        busy_o;

    mem_arbiter #(.AWIDTH(32), .DWIDTH(32), .MEM_LAT(LAT)) dut (
        .clk           (clk),
        .rst           (rst),
        .if_req_i      (if_req_i),
        .if_addr_i     (if_addr_i),
        .if_gnt_o      (if_gnt_o),
        .if_rvalid_o   (if_rvalid_o),
        .if_rdata_o    (if_rdata_o),
        .d_req_i       (d_req_i),
        .d_we_i        (d_we_i),
        .d_addr_i      (d_addr_i),
        .d_wdata_i     (d_wdata_i),
        .d_gnt_o       (d_gnt_o),
        .d_rvalid_o    (d_rvalid_o),
        .d_rdata_o     (d_rdata_o),
        .mem_addr_o    (mem_addr_o),
        .mem_data_o    (mem_data_o),
        .mem_read_en_o (mem_read_en_o),
        .mem_write_en_o(mem_write_en_o),
        .mem_data_i    (mem_data_i),
        .busy_o        (busy_o)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%h expected=%h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Pending requester offers (held until granted)
    bit          if_pend, d_pend, d_w;
    logic [31:0] if_a, d_a, d_wd;

    // Reference model: timing of the single outstanding transaction in cycles
    int          n;
    int          t_g;
    int          next_free;
    bit          t_data, t_we, last_if;
    logic [31:0] m_addr, t_wd, m_resp;

    task automatic model_reset();
        t_g       = -1000;
        next_free = n;
        t_data    = 1'b0;
        t_we      = 1'b0;
        last_if   = 1'b1;
        m_addr    = '0;
        t_wd      = '0;
        m_resp    = '0;
    endtask

    task automatic step(input logic [31:0] md);
        bit eg_i, eg_d, e_re, e_we, e_busy, e_irv, e_drv;
        @(negedge clk);
        if_req_i   = if_pend;
        if_addr_i  = if_a;
        d_req_i    = d_pend;
        d_we_i     = d_w;
        d_addr_i   = d_a;
        d_wdata_i  = d_wd;
        mem_data_i = md;
        #1;
        eg_i = 1'b0;
        eg_d = 1'b0;
        if (n >= next_free) begin
            if (if_pend && d_pend) begin
`ifdef ARB_ROUND_ROBIN_EN
                eg_d = last_if;
                eg_i = !last_if;
`else
                eg_d = 1'b1;
`endif
            end else begin
                eg_i = if_pend;
                eg_d = d_pend;
            end
        end
        e_re   = (n == t_g + 1) && !t_we;
        e_we   = (n == t_g + 1) && t_we;
        e_busy = (n > t_g) && (n <= t_g + LAT + 1);
        e_irv  = (n == t_g + LAT + 1) && !t_data;
        e_drv  = (n == t_g + LAT + 1) && t_data;

        check("if_gnt", 64'(if_gnt_o), 64'(eg_i));
        check("d_gnt", 64'(d_gnt_o), 64'(eg_d));
        check("mem_read_en", 64'(mem_read_en_o), 64'(e_re));
        check("mem_write_en", 64'(mem_write_en_o), 64'(e_we));
        check("busy", 64'(busy_o), 64'(e_busy));
        check("if_rvalid", 64'(if_rvalid_o), 64'(e_irv));
        check("d_rvalid", 64'(d_rvalid_o), 64'(e_drv));
        check("mem_addr", 64'(mem_addr_o), 64'(m_addr));
        if (e_we) check("mem_data", 64'(mem_data_o), 64'(t_wd));
        if (e_irv) check("if_rdata", 64'(if_rdata_o), 64'(m_resp));
        if (e_drv) check("d_rdata", 64'(d_rdata_o), 64'(m_resp));

        if (n == t_g + LAT) m_resp = t_we ? 32'h0 : md;
        if (eg_i || eg_d) begin
            t_g       = n;
            t_data    = eg_d;
            t_we      = eg_d && d_w;
            m_addr    = eg_d ? d_a : if_a;
            if (eg_d) t_wd = d_wd;
            next_free = n + LAT + 2;
            last_if   = eg_i;
            if (eg_i) if_pend = 1'b0;
            if (eg_d) d_pend = 1'b0;
        end
        n++;
    endtask

    task automatic random_offers();
        if (!if_pend && ($urandom % 3 == 0)) begin
            if_pend = 1'b1;
            if_a    = $urandom;
        end
        if (!d_pend && ($urandom % 3 == 0)) begin
            d_pend = 1'b1;
            d_w    = 1'($urandom);
            d_a    = $urandom;
            d_wd   = $urandom;
        end
    endtask

    initial begin
        n = 0;
        if_pend = 0; d_pend = 0; d_w = 0;
        if_a = '0; d_a = '0; d_wd = '0;
        if_req_i = 0; if_addr_i = '0; d_req_i = 0; d_we_i = 0;
        d_addr_i = '0; d_wdata_i = '0; mem_data_i = '0;
        rst = 1'b0;
        model_reset();
        #12;
        check("rst_busy", 64'(busy_o), 64'd0);
        check("rst_mem_addr", 64'(mem_addr_o), 64'd0);
        check("rst_if_rdata", 64'(if_rdata_o), 64'd0);
        check("rst_d_rdata", 64'(d_rdata_o), 64'd0);
        check("rst_enables", 64'({mem_read_en_o, mem_write_en_o}), 64'd0);
        @(posedge clk);
        #2 rst = 1'b1;
        model_reset();

        // Fetch with known memory word
        if_pend = 1'b1;
        if_a    = 32'h0100_0000;
        repeat (LAT + 3) step(32'h0050_0093);

        // Store
        d_pend = 1'b1; d_w = 1'b1; d_a = 32'h0100_0010; d_wd = 32'hDEAD_BEEF;
        repeat (LAT + 3) step($urandom);

        // Continuous contention for four grants
        for (int i = 0; i < 4 * (LAT + 2); i++) begin
            if_pend = 1'b1;
            if (!d_pend) begin
                d_pend = 1'b1; d_w = 1'($urandom); d_a = $urandom; d_wd = $urandom;
            end
            step($urandom);
        end
        if_pend = 1'b0;
        d_pend  = 1'b0;
        repeat (LAT + 3) step($urandom);

        for (int i = 0; i < 400; i++) begin
            random_offers();
            step($urandom);
        end

        // Reset in the middle of a load
        if_pend = 1'b0;
        d_pend = 1'b1; d_w = 1'b0; d_a = $urandom; d_wd = $urandom;
        for (int i = 0; i < 20 && d_pend; i++) step($urandom);
        check("load_grant_timeout", 64'(d_pend), 64'd0);
        @(posedge clk);
        #2;
        if_req_i = 1'b1;
        d_req_i  = 1'b1;
        rst      = 1'b0;
        #1;
        check("mid_rst_busy", 64'(busy_o), 64'd0);
        check("mid_rst_grants", 64'({if_gnt_o, d_gnt_o}), 64'd0);
        check("mid_rst_enables", 64'({mem_read_en_o, mem_write_en_o}), 64'd0);
        check("mid_rst_rvalid", 64'({if_rvalid_o, d_rvalid_o}), 64'd0);
        repeat (2) @(posedge clk);
        #2 rst = 1'b1;
        model_reset();
        d_pend  = 1'b0;
        if_pend = 1'b1;
        if_a    = $urandom;
        repeat (LAT + 4) step($urandom);

        for (int i = 0; i < 100; i++) begin
            random_offers();
            step($urandom);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter AWIDTH, default 32, address width.
REQ-002 Parameter DWIDTH, default 32, data width.
REQ-003 Parameter MEM_LAT, default 1, memory access latency in cycles; legal range 1..7.
REQ-004 Port clk  input  1  sole clock; all state on rising edge.
REQ-005 Port rst  input  1  asynchronous, active-low reset.
REQ-006 Port if_req_i  input  1  fetch read request; held until if_gnt_o.
REQ-007 Port if_addr_i  input  AWIDTH  fetch address.
REQ-008 Port if_gnt_o  output  1  fetch request accepted this cycle.
REQ-009 Port if_rvalid_o  output  1  one-cycle fetch response strobe.
REQ-010 Port if_rdata_o  output  DWIDTH  fetch response data.
REQ-011 Port d_req_i  input  1  data request; held until d_gnt_o.
REQ-012 Port d_we_i  input  1  1 = store, 0 = load.
REQ-013 Port d_addr_i  input  AWIDTH  data address.
REQ-014 Port d_wdata_i  input  DWIDTH  store data.
REQ-015 Port d_gnt_o  output  1  data request accepted this cycle.
REQ-016 Port d_rvalid_o  output  1  one-cycle load data / store acknowledge strobe.
REQ-017 Port d_rdata_o  output  DWIDTH  load data; 0 for store acknowledges.
REQ-018 Port mem_addr_o, mem_data_o  output  AWIDTH, DWIDTH  shared memory address and write data.
REQ-019 Port mem_read_en_o, mem_write_en_o  output  1 each  shared memory enables.
REQ-020 Port mem_data_i  input  DWIDTH  shared memory read data.
REQ-021 Port busy_o  output  1  high whenever state is not IDLE.

Function
REQ-022 FSM states IDLE, ACCESS, RESP; owner register records IF or DATA.
REQ-023 IDLE, no requests: stay IDLE, all grants 0.
REQ-024 IDLE, at least one request: exactly one gnt_o asserted combinationally; on that edge latch owner, address, we, wdata; load latency counter with MEM_LAT-1; go to ACCESS.
REQ-025 Grants only in IDLE; never two grants in one cycle; requests during ACCESS/RESP are ignored.
REQ-026 ACCESS: mem_addr_o/mem_data_o driven from latched registers; mem_read_en_o (load/fetch) or mem_write_en_o (store) high in first ACCESS cycle only.
REQ-027 ACCESS: counter decrements each cycle; at counter 0, capture mem_data_i (loads/fetches) or 0 (stores) into response register and go to RESP.
REQ-028 RESP: owner's rvalid_o high exactly one cycle with captured data; other rvalid_o 0; go to IDLE.
REQ-029 Latency: rvalid_o asserted MEM_LAT+1 cycles after grant cycle; next grant earliest MEM_LAT+2 cycles after previous grant.
REQ-030 Fetch requests are always reads; if_* never causes mem_write_en_o.
REQ-031 Addresses passed unmodified; no alignment checking or fault reporting.
REQ-032 rdata_o outputs hold last captured value between strobes; mem_addr_o holds latched address when idle; enables 0 outside first ACCESS cycle.

Reset
REQ-033 rst low: state IDLE, owner IF, counter 0, latched address/data 0, response register 0, last-granted IF, immediately and independent of clk.
REQ-034 Reset mid-transaction abandons it: no rvalid_o, enables and grants drop to 0 asynchronously.
REQ-035 First grant possible in first cycle after rst deasserts.

Configuration
REQ-036 Macro ARB_ROUND_ROBIN_EN defined: on simultaneous requests, grant the requester not granted last; last-granted updates on every grant; resets to IF, so first contention grants DATA.
REQ-037 Macro undefined: fixed priority, DATA always wins contention; fetch waits indefinitely while d_req_i stays high.

Verification
REQ-038 MEM_LAT=2, if_req_i=1, if_addr_i=0x01000000, mem_data_i=0x00500093 -> if_gnt_o cycle 0, mem_read_en_o cycle 1 only, if_rvalid_o cycle 3 with if_rdata_o=0x00500093.
REQ-039 Store d_we_i=1, d_addr_i=0x01000010, d_wdata_i=0xDEADBEEF -> mem_write_en_o one cycle with mem_addr_o=0x01000010, mem_data_o=0xDEADBEEF; d_rvalid_o with d_rdata_o=0; if_rvalid_o stays 0.
REQ-040 Both requests held continuously, macro undefined -> 4 consecutive grants all d_gnt_o, spaced MEM_LAT+2 cycles.
REQ-041 Both requests held continuously, ARB_ROUND_ROBIN_EN defined -> grants alternate DATA, IF, DATA, IF.
REQ-042 rst pulsed low during ACCESS of a load -> no d_rvalid_o, busy_o=0 immediately, new if_req_i granted first cycle after release.
REQ-043 MEM_LAT=1, single load -> mem_read_en_o one cycle, d_rvalid_o 2 cycles after grant.
